ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2500, the clock-low inhibit time in px_clk cycles (100 us at 25 MHz).
REQ-002 SHALL have parameter START_TIMEOUT, default 375000, the maximum cycles from clock release to the first device falling edge (15 ms).
REQ-003 SHALL have parameter PACKET_TIMEOUT, default 50000, the maximum cycles from the first falling edge to the ack sample (2 ms).
REQ-004 px_clk  input  1  single clock for all logic.
REQ-005 clr  input  1  reset, asynchronous, active-low.
REQ-006 ps2_clk  input  1  raw PS/2 clock line; synchronized internally with 2 flops.
REQ-007 ps2_data  input  1  raw PS/2 data line; synchronized internally with 2 flops.
REQ-008 ps2_clk_oe  output  1  1 = pull clock line low (open-drain).
REQ-009 ps2_data_oe  output  1  1 = pull data line low (open-drain).
REQ-010 tx_byte  input  8  command byte to send.
REQ-011 tx_valid  input  1  request; accepted on a cycle where tx_valid & tx_ready.
REQ-012 tx_ready  output  1  high only in IDLE.
REQ-013 tx_done  output  1  one-cycle pulse on successful completion.
REQ-014 tx_err  output  1  one-cycle pulse on timeout or missing ack.
REQ-015 busy  output  1  equals ~tx_ready; the keyboard receiver ignores frames while it is high.

Function
REQ-016 States SHALL be: IDLE, INHIBIT, START, BITS, ACK, WAIT_IDLE.
REQ-017 Accept SHALL latch frame = {1'b1 stop, ~^tx_byte odd parity, tx_byte}, clear the cycle counter, set ps2_clk_oe, and enter INHIBIT.
REQ-018 INHIBIT SHALL hold ps2_clk_oe=1 for INHIBIT_CYCLES cycles, then set ps2_data_oe=1 (start bit) and enter START.
REQ-019 START SHALL hold both oe=1 for 16 cycles, then clear ps2_clk_oe, clear the counter, and enter BITS.
REQ-020 A falling edge SHALL be the synchronized-clock history pattern 2'b10 (old=1, new=0).
REQ-021 In BITS, each falling edge SHALL set ps2_data_oe = ~frame[0], shift frame right, and increment the bit count; edges 1-8 carry data LSB first, edge 9 parity, edge 10 stop (oe=0); after edge 10 enter ACK.
REQ-022 ACK SHALL sample the synchronized data on the next falling edge; 0 = ack; then enter WAIT_IDLE.
REQ-023 WAIT_IDLE SHALL wait until synchronized clock and data are both 1, then pulse tx_done (ack) or tx_err (nack) and enter IDLE.
REQ-024 Timeout SHALL apply as follows: no falling edge within START_TIMEOUT cycles of clock release, or ACK not reached within PACKET_TIMEOUT cycles of the first edge -> both oe=0, tx_err pulse, IDLE next cycle.
REQ-025 tx_valid outside IDLE SHALL be ignored, with no queuing.
REQ-026 tx_done and tx_err SHALL never be asserted together; the error path wins if both conditions occur in the same cycle.
REQ-027 The counter SHALL be 19 bits wide and saturate, never wrap.

Reset
REQ-028 clr low SHALL asynchronously force IDLE, both oe=0, tx_ready=1, tx_done=0, tx_err=0, busy=0, frame=0, counters=0, and sync flops=2'b11.
REQ-029 Reset mid-transfer SHALL release both lines immediately, with no done/err pulse.

Configuration
REQ-030 With PS2_TX_ACK_CHECK_EN defined, a nack SHALL produce tx_err per REQ-023.
REQ-031 Without PS2_TX_ACK_CHECK_EN, the ack value SHALL be ignored and tx_done pulses after WAIT_IDLE; timeouts still produce tx_err.

Structure
REQ-032 A shared package SHALL hold the state enum and localparams START_HOLD=16, FRAME_BITS=10, and the command constants SET_LEDS=8'hED and RESET_CMD=8'hFF.
REQ-033 One sub-module ps2_line_sync SHALL provide the 2-flop synchronizers and falling-edge detect, reusable by the receiver.

Verification
REQ-034 Send 0xED with a device model that acks -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1 on edges 1-10; tx_done pulse; tx_err=0.
REQ-035 Send 0x01 -> parity 0; clock held low for exactly 2500 cycles before the start bit.
REQ-036 Device model never clocks -> tx_err pulses 375000 cycles after clock release; both oe=0; tx_ready=1.
REQ-037 Device model stops after edge 5 -> tx_err pulses at PACKET_TIMEOUT.
REQ-038 Device holds data=1 at ack -> tx_err with PS2_TX_ACK_CHECK_EN defined, tx_done without it.
REQ-039 Assert clr during BITS -> oe lines drop asynchronously; a following tx_valid of 0xFF completes normally.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmit path and its line synchronizer.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam int CNT_W      = 19;
    localparam int START_HOLD = 16;
    localparam int FRAME_BITS = 10;

    localparam logic [7:0] SET_LEDS  = 8'hED;
    localparam logic [7:0] RESET_CMD = 8'hFF;

    // Shift order out of bit 0: data LSB first, odd parity, then stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus clock falling-edge detect.
module ps2_line_sync (
    input  logic px_clk,
    input  logic clr,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;

    // Lines idle high, so reset to the idle level to avoid a false edge.
    always_ff @(posedge px_clk or negedge clr) begin
        if (!clr) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s    = clk_sync[1];
    assign data_s   = data_sync[1];
    assign clk_fall = ({clk_prev, clk_sync[1]} == 2'b10);

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter; define PS2_TX_ACK_CHECK_EN to turn a device nack into tx_err.
//   state     | meaning
//   IDLE      | ready for a command byte
//   INHIBIT   | clock held low to abort any device transfer
//   START     | clock and data low (request-to-send)
//   BITS      | clock released, data/parity/stop shifted on device falling edges
//   ACK       | waiting for the device ack bit
//   WAIT_IDLE | waiting for both lines to return high
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int START_TIMEOUT  = 375000,
    parameter int PACKET_TIMEOUT = 50000
) (
    input  logic       px_clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(START_HOLD - 1);
    localparam logic [CNT_W-1:0] START_TO_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PKT_TO_LAST  = CNT_W'(PACKET_TIMEOUT - 1);
    localparam logic [3:0]       LAST_BIT     = 4'(FRAME_BITS - 1);

    logic clk_s, data_s, clk_fall;

    ps2_line_sync u_sync (
        .px_clk   (px_clk),
        .clr      (clr),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .clk_fall (clk_fall)
    );

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [FRAME_BITS-1:0]   frame, frame_nxt;
    logic [3:0]              bit_cnt, bit_cnt_nxt;
    logic                    clk_oe_q, clk_oe_nxt;
    logic                    data_oe_q, data_oe_nxt;
    logic                    done_q, done_nxt;
    logic                    err_q, err_nxt;
    logic                    ack_ok, ack_nxt;
    logic                    timeout;

    always_ff @(posedge px_clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= '0;
            frame     <= '0;
            bit_cnt   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_ok    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            frame     <= frame_nxt;
            bit_cnt   <= bit_cnt_nxt;
            clk_oe_q  <= clk_oe_nxt;
            data_oe_q <= data_oe_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            ack_ok    <= ack_nxt;
        end
    end

    // Before the first device edge the start window applies; afterwards the packet window.
    always_comb begin
        timeout = 1'b0;
        if (state == BITS && bit_cnt == 4'd0)
            timeout = (cnt >= START_TO_LAST);
        else if (state == BITS || state == ACK)
            timeout = (cnt >= PKT_TO_LAST);
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (&cnt) ? cnt : cnt + 1'b1;
        frame_nxt   = frame;
        bit_cnt_nxt = bit_cnt;
        clk_oe_nxt  = clk_oe_q;
        data_oe_nxt = data_oe_q;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        ack_nxt     = ack_ok;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    frame_nxt   = build_frame(tx_byte);
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                    clk_oe_nxt  = 1'b1;
                    data_oe_nxt = 1'b0;
                    ack_nxt     = 1'b0;
                    state_nxt   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt >= INHIBIT_LAST) begin
                    data_oe_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = START;
                end
            end
            START: begin
                if (cnt >= HOLD_LAST) begin
                    clk_oe_nxt = 1'b0;
                    cnt_nxt    = '0;
                    state_nxt  = BITS;
                end
            end
            BITS: begin
                if (timeout) begin
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    state_nxt   = IDLE;
                end else if (clk_fall) begin
                    data_oe_nxt = ~frame[0];
                    frame_nxt   = {1'b0, frame[FRAME_BITS-1:1]};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd0)
                        cnt_nxt = '0;
                    if (bit_cnt == LAST_BIT)
                        state_nxt = ACK;
                end
            end
            ACK: begin
                if (timeout) begin
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    state_nxt   = IDLE;
                end else if (clk_fall) begin
                    ack_nxt   = ~data_s;
                    state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    done_nxt = ack_ok;
                    err_nxt  = ~ack_ok;
`else
                    done_nxt = 1'b1;
`endif
                    state_nxt = IDLE;
                end
            end
            default: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_ready    = (state == IDLE);
    assign busy        = ~tx_ready;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule
